dadder_cp_responder: RTL and testbench

Responder (DUT-side) end of the dadder control-plane interface: accepts register read/write requests from the CP initiator and returns one response per granted request. Holds operand and control registers and runs a multi-cycle add sequencer. Sits between the CP bus and the dadder datapath, and is the block the CP agent drives and the CP interface checker binds against.

---
 rtl/dadder_cp_responder.sv | 195 +++++++++++++++++++
 tb/tb_dadder_cp_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dadder_cp_responder.sv
`default_nettype none
// ============================================================================
// Module   : dadder_cp_responder
// Purpose  : Responder end of the dadder control-plane (CP) interface.
//            Accepts one register read/write request at a time, returns one
//            response per granted request, and holds the operand/control
//            registers plus a multi-cycle add sequencer.
// Ports    : clk, reset (async, active-high)
//            req/gnt/we/addr/wdata  - request channel (accepted on req&gnt)
//            rvalid/rready/rdata/err- response channel (held until accepted)
//            busy                   - add in progress (STATUS[0])
// Register map (byte address, bits [1:0] ignored):
//            0x00 CTRL  W : bit0 start, bit1 clr_done (reads 0)
//            0x04 OP_A  RW
//            0x08 OP_B  RW
//            0x0C RESULT RO
//            0x10 STATUS RO: bit0 busy, bit1 carry, bit2 done
// Option   : DADDER_CP_ERR_EN - when defined, unmapped accesses and writes
//            to RESULT/STATUS return err=1, rdata=0, with no side effect.
// Revision : 1.0 - initial release
// ============================================================================
module dadder_cp_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int ADD_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              gnt,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy
);

    localparam logic [ADDR_W-3:0] c_W_CTRL   = (ADDR_W-2)'(0);
    localparam logic [ADDR_W-3:0] c_W_OP_A   = (ADDR_W-2)'(1);
    localparam logic [ADDR_W-3:0] c_W_OP_B   = (ADDR_W-2)'(2);
    localparam logic [ADDR_W-3:0] c_W_RESULT = (ADDR_W-2)'(3);
    localparam logic [ADDR_W-3:0] c_W_STATUS = (ADDR_W-2)'(4);
    localparam logic [3:0]        c_LAT      = 4'(ADD_LATENCY);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t r_state, w_state_nxt;

    logic [DATA_W-1:0] r_op_a, r_op_b, r_snap_a, r_snap_b, r_result, r_rdata;
    logic [3:0]        r_cnt;
    logic              r_busy, r_carry, r_done, r_err;

    logic              w_acc, w_rvalid, w_bad, w_wr, w_rd;
    logic              w_sel_ctrl, w_sel_a, w_sel_b, w_sel_res, w_sel_stat, w_mapped;
    logic              w_start, w_clr, w_complete;
    logic [ADDR_W-3:0] w_word;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_rdata_mux;
    logic [1:0]        w_unused_addr_bits;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_rvalid = (r_state == ST_RESP);
    // A new request can be taken while the current response is being
    // consumed, which gives one response per cycle on back-to-back traffic.
    assign gnt      = !reset && (r_state == ST_IDLE || (w_rvalid && rready));
    assign w_acc    = req && gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            w_state_nxt = ST_RESP;
        end else if (w_rvalid && rready) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_word             = addr[ADDR_W-1:2];
    assign w_unused_addr_bits = addr[1:0];
    assign w_sel_ctrl         = (w_word == c_W_CTRL);
    assign w_sel_a            = (w_word == c_W_OP_A);
    assign w_sel_b            = (w_word == c_W_OP_B);
    assign w_sel_res          = (w_word == c_W_RESULT);
    assign w_sel_stat         = (w_word == c_W_STATUS);
    assign w_mapped           = w_sel_ctrl | w_sel_a | w_sel_b | w_sel_res | w_sel_stat;

`ifdef DADDER_CP_ERR_EN
    assign w_bad = !w_mapped || (we && (w_sel_res || w_sel_stat));
`else
    assign w_bad = 1'b0;
`endif

    // Erroring accesses are stripped of all side effects here.
    assign w_wr = w_acc && we  && !w_bad;
    assign w_rd = w_acc && !we && !w_bad;

    always_comb begin
        w_rdata_mux = '0;
        if (w_sel_a) begin
            w_rdata_mux = r_op_a;
        end else if (w_sel_b) begin
            w_rdata_mux = r_op_b;
        end else if (w_sel_res) begin
            w_rdata_mux = r_result;
        end else if (w_sel_stat) begin
            w_rdata_mux[2:0] = {r_done, r_carry, r_busy};
        end
    end

    // ------------------------------------------------------------------
    // Add sequencer
    // ------------------------------------------------------------------
    assign w_start    = w_wr && w_sel_ctrl && wdata[0] && !r_busy;
    assign w_clr      = (w_rd && w_sel_stat) || (w_wr && w_sel_ctrl && wdata[1]);
    assign w_complete = r_busy && (r_cnt == 4'd1);
    assign w_sum      = {1'b0, r_snap_a} + {1'b0, r_snap_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_snap_a <= '0;
            r_snap_b <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_carry  <= 1'b0;
            r_done   <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_wr && w_sel_a) begin
                r_op_a <= wdata;
            end
            if (w_wr && w_sel_b) begin
                r_op_b <= wdata;
            end

            // The add runs on snapshots so operand writes during an add
            // only affect the next one.
            if (w_start) begin
                r_snap_a <= r_op_a;
                r_snap_b <= r_op_b;
                r_busy   <= 1'b1;
                r_cnt    <= c_LAT;
            end else if (w_complete) begin
                r_result <= w_sum[DATA_W-1:0];
                r_carry  <= w_sum[DATA_W];
                r_busy   <= 1'b0;
                r_cnt    <= '0;
            end else if (r_busy) begin
                r_cnt    <= r_cnt - 4'd1;
            end

            // Completion has priority over a same-cycle clear.
            if (w_complete) begin
                r_done <= 1'b1;
            end else if (w_clr) begin
                r_done <= 1'b0;
            end

            // Response payload is captured only on acceptance, so it stays
            // stable for as long as the initiator stalls.
            if (w_acc) begin
                r_rdata <= w_rd ? w_rdata_mux : '0;
                r_err   <= w_bad;
            end
        end
    end

    assign rvalid = w_rvalid;
    assign rdata  = r_rdata;
    assign err    = r_err;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dadder_cp_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dadder_cp_responder
// Purpose  : Directed self-checking bench for dadder_cp_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dadder_cp_responder;

`ifdef DADDER_CP_ERR_EN
    localparam logic c_ERR = 1'b1;
`else
    localparam logic c_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, rready;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        gnt, rvalid, err, busy;
    logic [31:0] rdata;

    int   n_vec = 0;
    int   n_err = 0;
    logic resp_busy;

    dadder_cp_responder #(
        .ADDR_W      (8),
        .DATA_W      (32),
        .ADD_LATENCY (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .gnt    (gnt),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .err    (err),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd_o, output logic err_o);
        int n;
        n = 0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; rready = 1'b1;
        while (!gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("gnt_wait", {31'b0, gnt}, 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("rvalid", {31'b0, rvalid}, 32'd1);
        rd_o = rdata; err_o = err; resp_busy = busy;
        @(posedge clk); #1;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d; logic e;
        xfer(1'b0, a, 32'h0, d, e);
        chk(tag, d, exp);
        chk({tag, "_err"}, {31'b0, e}, 32'd0);
    endtask

    task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d, input logic exp_err);
        logic [31:0] r; logic e;
        xfer(1'b1, a, d, r, e);
        chk({tag, "_rdata"}, r, 32'd0);
        chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk(tag, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int          cyc;
        logic [31:0] d;
        logic        e;

        reset = 1'b1; req = 1'b0; we = 1'b0; rready = 1'b1;
        addr = '0; wdata = '0;
        #1;
        chk("rst_gnt",    {31'b0, gnt},    32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata",  rdata,           32'd0);
        chk("rst_err",    {31'b0, err},    32'd0);
        chk("rst_busy",   {31'b0, busy},   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        chk("idle_gnt", {31'b0, gnt}, 32'd1);

        // 5 + 7, busy visible for exactly 3 cycles
        wr("wr_a", 8'h04, 32'h0000_0005, 1'b0);
        wr("wr_b", 8'h08, 32'h0000_0007, 1'b0);
        wr("start1", 8'h00, 32'h1, 1'b0);
        cyc = resp_busy ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
        end
        chk("busy_cycles", cyc, 32'd3);
        rd("result1", 8'h0C, 32'h0000_000C);
        rd("status1", 8'h10, 32'h4);
        rd("status1_clr", 8'h10, 32'h0);

        // carry out
        wr("wr_a2", 8'h04, 32'hFFFF_FFFF, 1'b0);
        wr("wr_b2", 8'h08, 32'h0000_0002, 1'b0);
        wr("start2", 8'h00, 32'h1, 1'b0);
        wait_idle("idle2");
        rd("result2", 8'h0C, 32'h0000_0001);

        // Stalled response, with the next request waiting behind it
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 8'h04; rready = 1'b0;
        @(posedge clk); #1;
        addr = 8'h08;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rvalid", {31'b0, rvalid}, 32'd1);
            chk("stall_rdata",  rdata,           32'hFFFF_FFFF);
            chk("stall_gnt",    {31'b0, gnt},    32'd0);
        end
        rready = 1'b1;
        #1;
        chk("b2b_gnt", {31'b0, gnt}, 32'd1);
        @(posedge clk); #1;
        addr = 8'h0C;
        @(negedge clk);
        chk("b2b_rvalid1", {31'b0, rvalid}, 32'd1);
        chk("b2b_rdata1",  rdata,           32'h0000_0002);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("b2b_rvalid2", {31'b0, rvalid}, 32'd1);
        chk("b2b_rdata2",  rdata,           32'h0000_0001);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_drain", {31'b0, rvalid}, 32'd0);
        rd("status2", 8'h10, 32'h6);

        // Operand write during an add does not disturb it
        wr("wr_a3", 8'h04, 32'h1, 1'b0);
        wr("wr_b3", 8'h08, 32'h1, 1'b0);
        wr("start3", 8'h00, 32'h1, 1'b0);
        wr("wr_a_busy", 8'h04, 32'h10, 1'b0);
        chk("wr_during_busy", {31'b0, resp_busy}, 32'd1);
        wait_idle("idle3");
        rd("result3", 8'h0C, 32'h2);
        rd("op_a3", 8'h04, 32'h10);
        rd("op_a3_lowbits", 8'h05, 32'h10);
        wr("clr_done", 8'h00, 32'h2, 1'b0);
        rd("status3", 8'h10, 32'h0);

        // Unmapped access / RO write
        xfer(1'b0, 8'h20, 32'h0, d, e);
        chk("unmapped_rdata", d, 32'h0);
        chk("unmapped_err",   {31'b0, e}, {31'b0, c_ERR});
        wr("wr_result", 8'h0C, 32'hDEAD_BEEF, c_ERR);
        rd("result_kept", 8'h0C, 32'h2);

        // Reset during an add
        wr("wr_b4", 8'h08, 32'h1, 1'b0);
        wr("start4", 8'h00, 32'h1, 1'b0);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("rst_add_busy",   {31'b0, busy},   32'd0);
        chk("rst_add_rvalid", {31'b0, rvalid}, 32'd0);
        @(negedge clk); reset = 1'b0;

        // Reset during a pending response
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 8'h08; rready = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("pend_rvalid", {31'b0, rvalid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_pend_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_pend_rdata",  rdata,           32'd0);
        @(negedge clk); reset = 1'b0; rready = 1'b1;
        rd("result_rst", 8'h0C, 32'h0);
        rd("op_a_rst",   8'h04, 32'h0);
        rd("status_rst", 8'h10, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
